// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared types for the matrix instruction sequencer
// Purpose: opcode constant, funct3 encodings, instruction field layout and
//          sequencer FSM states used by matrix_ctrl_sequencer and its bench.
// Ports:   none (package).
package types_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] MATRIX_OPCODE = 7'b0001011;

  typedef enum logic [2:0] {
    LD_M = 3'b000,
    ST_M = 3'b001,
    GEMM = 3'b010
  } matrix_funct3_t;

  // R4-style layout; matrix register indices live in the low bits of each
  // 5-bit register field.
  typedef struct packed {
    logic [4:0] mc;
    logic [1:0] funct2;
    logic [4:0] mb;
    logic [4:0] ma;
    logic [2:0] funct3;
    logic [4:0] md;
    logic [6:0] opcode;
  } matrix_instr_t;

  typedef enum logic [1:0] {
    IDLE,
    MEM_SEQ,
    GEMM_ISSUE
  } mseq_state_t;

endpackage

// File: rtl/matrix_scoreboard.sv
// rtl/matrix_scoreboard.sv - matrix register busy scoreboard
// Purpose: one busy bit per matrix register, one set port, two clear ports.
// Ports:   clk, rst_n (async active-low); set_en/set_idx marks a register
//          busy; clr0_en/clr0_idx and clr1_en/clr1_idx free registers;
//          busy is the registered vector used for hazard lookup.
module matrix_scoreboard #(
  parameter int NUM_MREGS = 8,
  parameter int MREG_W    = $clog2(NUM_MREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [MREG_W-1:0]    set_idx,
  input  logic                 clr0_en,
  input  logic [MREG_W-1:0]    clr0_idx,
  input  logic                 clr1_en,
  input  logic [MREG_W-1:0]    clr1_idx,
  output logic [NUM_MREGS-1:0] busy
);

  logic [NUM_MREGS-1:0] busy_next;

  // Set is applied after the clears; an accept never targets a busy
  // register, so set and clear never collide on one index.
  always_comb begin
    busy_next = busy;
    if (clr0_en) busy_next[clr0_idx] = 1'b0;
    if (clr1_en) busy_next[clr1_idx] = 1'b0;
    if (set_en)  busy_next[set_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/matrix_ctrl_sequencer.sv
// rtl/matrix_ctrl_sequencer.sv - matrix instruction decode, hazard and issue
// Purpose: decodes custom-0 ld.m/st.m/gemm, stalls on busy matrix registers,
//          expands ld.m/st.m into ROWS strided row requests and issues gemm.
// Ports:   CLK/nRST; instr/instr_valid/base_addr/stride in, instr_ready,
//          is_matrix, illegal out; mreq_* row request stream; mresp_* ld.m
//          completion; gemm_* issue handshake and completion; busy vector.
module matrix_ctrl_sequencer
  import types_pkg::*;
#(
  parameter int NUM_MREGS = 8,
  parameter int ROWS      = 4,
  parameter int ADDR_W    = 32,
  parameter int MREG_W    = $clog2(NUM_MREGS),
  parameter int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  word_t                instr,
  input  logic                 instr_valid,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    stride,
  output logic                 instr_ready,
  output logic                 is_matrix,
  output logic                 illegal,
  output logic                 mreq_valid,
  input  logic                 mreq_ready,
  output logic [ADDR_W-1:0]    mreq_addr,
  output logic                 mreq_write,
  output logic [MREG_W-1:0]    mreq_mreg,
  output logic [ROW_W-1:0]     mreq_row,
  output logic                 mreq_last,
  input  logic                 mresp_valid,
  input  logic [MREG_W-1:0]    mresp_mreg,
  output logic                 gemm_valid,
  input  logic                 gemm_ready,
  output logic [MREG_W-1:0]    gemm_md,
  output logic [MREG_W-1:0]    gemm_ma,
  output logic [MREG_W-1:0]    gemm_mb,
  output logic [MREG_W-1:0]    gemm_mc,
  input  logic                 gemm_done,
  input  logic [MREG_W-1:0]    gemm_done_md,
  output logic [NUM_MREGS-1:0] busy
);

  mseq_state_t         state;
  matrix_instr_t       dec;
  logic                is_custom, is_ld, is_st, is_gemm, is_mem;
  logic [MREG_W-1:0]   md, ma, mb, mc;
  logic                hazard, accept, sb_set;
  logic [ADDR_W-1:0]   stride_q;
  logic                unused_instr_bits;

  // Decode
  assign dec       = matrix_instr_t'(instr);
  assign is_custom = (dec.opcode == MATRIX_OPCODE);
  assign is_ld     = is_custom && (dec.funct3 == LD_M);
  assign is_st     = is_custom && (dec.funct3 == ST_M);
  assign is_gemm   = is_custom && (dec.funct3 == GEMM);
  assign is_mem    = is_ld || is_st;
  assign is_matrix = is_mem || is_gemm;

  assign md = dec.md[MREG_W-1:0];
  assign ma = dec.ma[MREG_W-1:0];
  assign mb = dec.mb[MREG_W-1:0];
  assign mc = dec.mc[MREG_W-1:0];

  // Upper register-field bits and funct2 are don't-care for this unit.
  assign unused_instr_bits = ^instr;

  // Scalar and illegal words never stall.
  always_comb begin
    hazard = 1'b0;
    if (is_mem)       hazard = busy[md];
    else if (is_gemm) hazard = busy[md] | busy[ma] | busy[mb] | busy[mc];
  end

  assign instr_ready = (state == IDLE) && !hazard;
  assign accept      = instr_valid && instr_ready;
  assign sb_set      = accept && (is_ld || is_gemm);
  assign mreq_last   = mreq_valid && (mreq_row == ROW_W'(ROWS - 1));

  matrix_scoreboard #(
    .NUM_MREGS (NUM_MREGS),
    .MREG_W    (MREG_W)
  ) u_scoreboard (
    .clk      (CLK),
    .rst_n    (nRST),
    .set_en   (sb_set),
    .set_idx  (md),
    .clr0_en  (mresp_valid),
    .clr0_idx (mresp_mreg),
    .clr1_en  (gemm_done),
    .clr1_idx (gemm_done_md),
    .busy     (busy)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      illegal    <= 1'b0;
      mreq_valid <= 1'b0;
      mreq_addr  <= '0;
      mreq_write <= 1'b0;
      mreq_mreg  <= '0;
      mreq_row   <= '0;
      stride_q   <= '0;
      gemm_valid <= 1'b0;
      gemm_md    <= '0;
      gemm_ma    <= '0;
      gemm_mb    <= '0;
      gemm_mc    <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mem) begin
              mreq_valid <= 1'b1;
              mreq_addr  <= base_addr;
              mreq_write <= is_st;
              mreq_mreg  <= md;
              mreq_row   <= '0;
              stride_q   <= stride;
              state      <= MEM_SEQ;
            end else if (is_gemm) begin
              gemm_valid <= 1'b1;
              gemm_md    <= md;
              gemm_ma    <= ma;
              gemm_mb    <= mb;
              gemm_mc    <= mc;
              state      <= GEMM_ISSUE;
            end else if (is_custom) begin
              illegal <= 1'b1;
            end
          end
        end
        MEM_SEQ: begin
          if (mreq_valid && mreq_ready) begin
            if (mreq_last) begin
              mreq_valid <= 1'b0;
              state      <= IDLE;
            end else begin
              mreq_row  <= mreq_row + ROW_W'(1);
              mreq_addr <= mreq_addr + stride_q;
            end
          end
        end
        GEMM_ISSUE: begin
          if (gemm_ready) begin
            gemm_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_ctrl_sequencer.sv
// tb/tb_matrix_ctrl_sequencer.sv - scoreboard bench for matrix_ctrl_sequencer
module tb_matrix_ctrl_sequencer;
  import types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  word_t       instr;
  logic        instr_valid;
  logic [31:0] base_addr, stride;
  logic        instr_ready, is_matrix, illegal;
  logic        mreq_valid, mreq_ready, mreq_write, mreq_last;
  logic [31:0] mreq_addr;
  logic [2:0]  mreq_mreg;
  logic [1:0]  mreq_row;
  logic        mresp_valid;
  logic [2:0]  mresp_mreg;
  logic        gemm_valid, gemm_ready, gemm_done;
  logic [2:0]  gemm_md, gemm_ma, gemm_mb, gemm_mc, gemm_done_md;
  logic [7:0]  busy;

  always #5 CLK = ~CLK;

  matrix_ctrl_sequencer dut (
    .CLK(CLK), .nRST(nRST), .instr(instr), .instr_valid(instr_valid),
    .base_addr(base_addr), .stride(stride), .instr_ready(instr_ready),
    .is_matrix(is_matrix), .illegal(illegal), .mreq_valid(mreq_valid),
    .mreq_ready(mreq_ready), .mreq_addr(mreq_addr), .mreq_write(mreq_write),
    .mreq_mreg(mreq_mreg), .mreq_row(mreq_row), .mreq_last(mreq_last),
    .mresp_valid(mresp_valid), .mresp_mreg(mresp_mreg),
    .gemm_valid(gemm_valid), .gemm_ready(gemm_ready), .gemm_md(gemm_md),
    .gemm_ma(gemm_ma), .gemm_mb(gemm_mb), .gemm_mc(gemm_mc),
    .gemm_done(gemm_done), .gemm_done_md(gemm_done_md), .busy(busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  mreg;
    logic [1:0]  row;
    logic        last;
  } mreq_t;

  typedef struct packed {
    logic [2:0] md, ma, mb, mc;
  } gemm_t;

  mreq_t mq[$];
  gemm_t gq[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [2:0] d,
                                     input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] c);
    logic [31:0] w;
    w        = '0;
    w[6:0]   = MATRIX_OPCODE;
    w[14:12] = f3;
    w[11:7]  = {2'b00, d};
    w[19:15] = {2'b00, a};
    w[24:20] = {2'b00, b};
    w[31:27] = {2'b00, c};
    return w;
  endfunction

  // Expected rows of one ld.m/st.m
  task automatic push_mem(input logic wr, input logic [2:0] m, input logic [31:0] b,
                          input logic [31:0] s, input int nrows);
    logic [31:0] a;
    a = b;
    for (int r = 0; r < nrows; r++) begin
      mq.push_back('{addr: a, write: wr, mreg: m, row: r[1:0], last: (r == 3)});
      a = a + s;
    end
  endtask

  // Output monitor: compare every completed handshake against the queues.
  always @(negedge CLK) begin
    mreq_t e;
    gemm_t g;
    if (nRST && mreq_valid && mreq_ready) begin
      if (mq.size() == 0) check("mreq_unexpected", 1, 0);
      else begin
        e = mq.pop_front();
        check("mreq", {mreq_addr, mreq_write, mreq_mreg, mreq_row, mreq_last}, e);
      end
    end
    if (nRST && gemm_valid && gemm_ready) begin
      if (gq.size() == 0) check("gemm_unexpected", 1, 0);
      else begin
        g = gq.pop_front();
        check("gemm", {gemm_md, gemm_ma, gemm_mb, gemm_mc}, g);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] i, input logic [31:0] b, input logic [31:0] s);
    int n;
    n = 0;
    instr = i; base_addr = b; stride = s; instr_valid = 1'b1;
    @(negedge CLK);
    while (!instr_ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 200) check("accept_timeout", 0, 1);
    @(posedge CLK); #1;
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || gq.size() != 0 || mreq_valid || gemm_valid) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    check("drain", (n < 500), 1);
  endtask

  task automatic pulse_mresp(input logic [2:0] m);
    mresp_mreg = m; mresp_valid = 1'b1;
    @(posedge CLK); #1;
    mresp_valid = 1'b0;
  endtask

  task automatic pulse_gdone(input logic [2:0] m);
    gemm_done_md = m; gemm_done = 1'b1;
    @(posedge CLK); #1;
    gemm_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; instr = '0; instr_valid = 1'b0; base_addr = '0; stride = '0;
    mreq_ready = 1'b1; mresp_valid = 1'b0; mresp_mreg = '0;
    gemm_ready = 1'b1; gemm_done = 1'b0; gemm_done_md = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 8'h00);
    check("rst_valids", {mreq_valid, gemm_valid, illegal}, 3'b000);
    check("rst_fields", {mreq_addr, mreq_row, mreq_mreg, gemm_md, gemm_ma, gemm_mb, gemm_mc}, '0);
    check("rst_ready", instr_ready, 1);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // ld.m md=3, base 0x1000, stride 0x40
    instr = mk(LD_M, 3, 0, 0, 0); #1;
    check("is_matrix_ld", is_matrix, 1);
    push_mem(1'b0, 3, 32'h1000, 32'h40, 4);
    issue(mk(LD_M, 3, 0, 0, 0), 32'h1000, 32'h40);
    check("ld_busy_set", busy, 8'h08);
    drain();
    check("ld_busy_hold", busy, 8'h08);
    pulse_mresp(3);
    check("ld_busy_clr", busy, 8'h00);

    // st.m with mreq_ready 1,0,0,1
    push_mem(1'b1, 5, 32'h2000, 32'h100, 4);
    issue(mk(ST_M, 5, 0, 0, 0), 32'h2000, 32'h100);
    @(posedge CLK); #1;
    mreq_ready = 1'b0;
    @(negedge CLK);
    check("st_stall1", {mreq_valid, mreq_addr, mreq_row, mreq_write}, {1'b1, 32'h2100, 2'd1, 1'b1});
    @(posedge CLK); #1;
    @(negedge CLK);
    check("st_stall2", {mreq_valid, mreq_addr, mreq_row, mreq_write}, {1'b1, 32'h2100, 2'd1, 1'b1});
    check("st_busy", busy, 8'h00);
    @(posedge CLK); #1;
    mreq_ready = 1'b1;
    drain();

    // Hazard: ld.m md=2 then gemm md=6 ma=2 mb=1 mc=0
    push_mem(1'b0, 2, 32'h3000, 32'h10, 4);
    issue(mk(LD_M, 2, 0, 0, 0), 32'h3000, 32'h10);
    instr = mk(GEMM, 6, 2, 1, 0); instr_valid = 1'b1;
    drain();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("hazard_stall", instr_ready, 0);
    end
    @(posedge CLK); #1;
    mresp_mreg = 2; mresp_valid = 1'b1;
    @(negedge CLK);
    check("hazard_clr_cycle", instr_ready, 0);
    @(posedge CLK); #1;
    mresp_valid = 1'b0; gemm_ready = 1'b0;
    @(negedge CLK);
    check("hazard_release", instr_ready, 1);
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("gemm_hold", {gemm_valid, gemm_md, gemm_ma, gemm_mb, gemm_mc},
            {1'b1, 3'd6, 3'd2, 3'd1, 3'd0});
    end
    check("gemm_busy", busy, 8'h40);
    gq.push_back('{md: 6, ma: 2, mb: 1, mc: 0});
    @(posedge CLK); #1;
    gemm_ready = 1'b1;
    drain();
    pulse_gdone(6);
    check("gemm_busy_clr", busy, 8'h00);

    // Address wrap
    push_mem(1'b0, 1, 32'hFFFF_FFC0, 32'h40, 4);
    issue(mk(LD_M, 1, 0, 0, 0), 32'hFFFF_FFC0, 32'h40);
    drain();
    pulse_mresp(1);
    check("wrap_busy_clr", busy, 8'h00);

    // Completion for a register that is not busy
    pulse_mresp(7);
    check("stray_resp", busy, 8'h00);

    // Illegal funct3
    instr = mk(3'b111, 1, 2, 3, 4); instr_valid = 1'b1;
    @(negedge CLK);
    check("illegal_decode", {is_matrix, instr_ready}, 2'b01);
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    check("illegal_pulse", {illegal, mreq_valid, gemm_valid, busy}, {3'b100, 8'h00});
    @(posedge CLK); #1;
    check("illegal_drop", illegal, 0);

    // Scalar addi
    instr = 32'h0050_0093; instr_valid = 1'b1;
    @(negedge CLK);
    check("scalar_decode", {is_matrix, instr_ready}, 2'b01);
    @(posedge CLK); #1;
    instr_valid = 1'b0;
    check("scalar_quiet", {illegal, mreq_valid, gemm_valid, busy}, {3'b000, 8'h00});

    // Reset during row 2
    push_mem(1'b0, 4, 32'h5000, 32'h8, 2);
    issue(mk(LD_M, 4, 0, 0, 0), 32'h5000, 32'h8);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("pre_reset_row", {mreq_valid, mreq_row}, {1'b1, 2'd2});
    nRST = 1'b0;
    #1;
    check("async_reset", {mreq_valid, busy}, {1'b0, 8'h00});
    @(negedge CLK);
    nRST = 1'b1;
    check("reset_queue", mq.size(), 0);
    @(posedge CLK); #1;
    push_mem(1'b0, 4, 32'h6000, 32'h4, 4);
    issue(mk(LD_M, 4, 0, 0, 0), 32'h6000, 32'h4);
    drain();
    pulse_mresp(4);
    check("final_busy", busy, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_ctrl_sequencer.md
Name: matrix_ctrl_sequencer

Overview:
- Next-generation control unit for matrix instructions (ld.m, st.m, gemm) in the tensor-core scalar pipeline.
- Decodes the custom-0 opcode and tracks matrix-register hazards with a busy scoreboard.
- Expands each ld.m/st.m into ROWS row-level memory requests with a strided address.
- Issues gemm to the systolic array with a valid/ready handshake.
- Scalar instructions bypass it: is_matrix=0, nothing issued.

Parameters:
- NUM_MREGS, 8, number of matrix registers; MREG_W = $clog2(NUM_MREGS).
- ROWS, 4, rows per matrix, i.e. memory requests per ld.m/st.m; ROW_W = $clog2(ROWS).
- ADDR_W, 32, memory address width.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- instr  in  32  instruction word (word_t)
- instr_valid  in  1  instr and operands valid
- base_addr  in  ADDR_W  rs1 value (matrix base address)
- stride  in  ADDR_W  rs2 value (row stride in bytes)
- instr_ready  out  1  instruction accepted this cycle when instr_valid is also 1
- is_matrix  out  1  combinational: opcode==custom-0 and funct3 legal
- illegal  out  1  one-cycle pulse: custom-0 opcode with undefined funct3 accepted
- mreq_valid  out  1  row memory request valid
- mreq_ready  in  1  memory accepts request
- mreq_addr  out  ADDR_W  row address
- mreq_write  out  1  1 = st.m row, 0 = ld.m row
- mreq_mreg  out  MREG_W  matrix register
- mreq_row  out  ROW_W  row index
- mreq_last  out  1  final row of the instruction
- mresp_valid  in  1  ld.m final-row data written to matrix register file
- mresp_mreg  in  MREG_W  register completed
- gemm_valid  out  1  gemm issue valid
- gemm_ready  in  1  systolic array accepts
- gemm_md, gemm_ma, gemm_mb, gemm_mc  out  MREG_W each  D = A*B + C operands
- gemm_done  in  1  gemm result written
- gemm_done_md  in  MREG_W  register completed
- busy  out  NUM_MREGS  scoreboard

Behaviour:
- Encoding: opcode 7'b0001011.
  - funct3 000 = ld.m, 001 = st.m, 010 = gemm; other values are illegal.
  - md = instr[7 +: MREG_W], ma = instr[15 +: MREG_W], mb = instr[20 +: MREG_W], mc = instr[27 +: MREG_W].
- FSM states: IDLE, MEM_SEQ, GEMM_ISSUE. Reset (async, nRST low) drives:
  - state IDLE, busy 0, all valids 0, illegal 0;
  - mreq_addr, mreq_row, mreq_mreg and all gemm_m* fields 0.
- instr_ready is asserted in IDLE when no hazard exists, and only then.
- Hazards are checked against the registered busy vector:
  - ld.m and st.m: busy[md].
  - gemm: busy of md, ma, mb or mc.
  - Scalar or illegal instructions never stall: instr_ready=1 in IDLE.
- IDLE accepting ld.m/st.m:
  - latch md, base_addr, stride and write flag;
  - row = 0, addr = base_addr;
  - ld.m sets busy[md];
  - go to MEM_SEQ next cycle with mreq_valid=1.
- MEM_SEQ:
  - Outputs are held stable while mreq_valid && !mreq_ready.
  - On a handshake: row++, addr += stride (modulo 2^ADDR_W, wraps silently).
  - mreq_last = (row == ROWS-1).
  - A handshake with mreq_last returns to IDLE the next cycle. Back-to-back acceptance is therefore possible, giving one idle request gap.
  - Latency: first request 1 cycle after accept; ROWS requests minimum over ROWS cycles.
- IDLE accepting gemm:
  - latch operands and set busy[md];
  - go to GEMM_ISSUE with gemm_valid=1, held until gemm_ready, then return to IDLE.
- Busy clear:
  - mresp_valid clears busy[mresp_mreg]; gemm_done clears busy[gemm_done_md].
  - Both may fire in the same cycle, on different or equal indices.
  - Clear and set on the same index in the same cycle cannot happen, because accept requires busy=0. The newly cleared register is usable one cycle later.
- Illegal funct3: the instruction is consumed, illegal pulses 1 cycle, no state change.
- A completion for a register that is not busy is ignored (no error).
- Reset mid-sequence aborts all outputs immediately. Outstanding responses after reset are the system's responsibility.

Decomposition:
- In types_pkg:
  - MATRIX_OPCODE constant;
  - matrix_funct3_t enum (LD_M, ST_M, GEMM);
  - matrix_instr_t packed struct;
  - mseq_state_t enum.
- Sub-module matrix_scoreboard: busy vector with set port plus two clear ports. Used for hazard lookup.
- Decode stays inline (combinational) in the top module.

Test Plan:
- ld.m md=3, base=0x1000, stride=0x40, ROWS=4, mreq_ready=1:
  - mreq addrs 0x1000, 0x1040, 0x1080, 0x10C0 with rows 0-3, mreq_last on row 3;
  - busy[3]=1 until mresp_valid with mreq 3.
- mreq_ready toggling 1,0,0,1 during st.m: addr, row and mreq_write=1 held stable while stalled; mreq_write is 1 throughout; busy unchanged.
- Hazard: ld.m md=2 in flight, then gemm ma=2:
  - instr_ready=0 until the cycle after mresp_mreg=2;
  - then gemm_valid with operands held through 3 cycles of gemm_ready=0.
- Stride wrap: base=0xFFFF_FFC0, stride=0x40 → addrs 0xFFFF_FFC0, 0x0, 0x40, 0x80.
- Illegal funct3=111 on custom-0 → illegal pulses 1 cycle, instr_ready=1, no mreq or gemm. Scalar opcode → is_matrix=0.
- nRST asserted mid-MEM_SEQ at row 2 → mreq_valid=0 and busy=0 asynchronously; the next ld.m restarts at row 0.
